// File: rtl/oai22_bist.sv
// BIST engine for a WIDTH-lane OAI22 gate array: 32 exhaustive vectors, two passes, error statistics.
// Optional OAI22_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module oai22_bist_lane #(
  parameter bit ODD = 1'b0
) (
  input  logic [4:0] i_k,
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_c,
  input  logic       i_d,
  input  logic       i_dut,
  output logic [3:0] o_stim,
  output logic       o_mis
);
  logic [3:0] w_v;
  assign w_v = i_k[3:0];
  // Second pass drives complementary patterns on odd lanes to expose lane-to-lane shorts.
  assign o_stim = (ODD && i_k[4]) ? ~w_v : w_v;
  assign o_mis  = i_dut ^ ~((i_a | i_b) & (i_c | i_d));
endmodule

module oai22_bist #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_in1,
  output logic [WIDTH-1:0] o_in2,
  output logic [WIDTH-1:0] o_in3,
  output logic [WIDTH-1:0] o_in4,
  input  logic [WIDTH-1:0] i_dut_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [5:0]       o_err_count,
  output logic [WIDTH-1:0] o_fail_mask,
  output logic [4:0]       o_first_fail,
  output logic             o_fail_valid
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [4:0]       r_k;
  logic [WIDTH-1:0] r_in1, r_in2, r_in3, r_in4;
  logic [WIDTH-1:0] r_mask;
  logic [5:0]       r_err;
  logic [4:0]       r_first;
  logic             r_fv, r_busy, r_done, r_pass;

  logic             w_accept, w_load, w_last, w_any, w_stop;
  logic [4:0]       w_k_load;
  logic [5:0]       w_err_nxt;
  logic [WIDTH-1:0] w_mis;
  logic [WIDTH-1:0][3:0] w_stim;

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    oai22_bist_lane #(.ODD(l % 2 == 1)) u_lane (
      .i_k   (w_k_load),
      .i_a   (r_in1[l]),
      .i_b   (r_in2[l]),
      .i_c   (r_in3[l]),
      .i_d   (r_in4[l]),
      .i_dut (i_dut_out[l]),
      .o_stim(w_stim[l]),
      .o_mis (w_mis[l])
    );
  end

  assign w_any     = |w_mis;
  assign w_last    = (r_k == 5'd31);
  assign w_err_nxt = w_any ? r_err + 6'd1 : r_err;
`ifdef OAI22_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_last | w_any;
`else
  assign w_stop = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_next = S_SETTLE;
      S_SETTLE:       w_next = S_CHECK;
      S_CHECK:        w_next = w_stop ? S_DONE : S_SETTLE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Next vector is loaded after every non-final check, even one that stops the run.
  always_comb begin
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_k_load = r_k + 5'd1;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_accept = i_start;
        w_load   = i_start;
        w_k_load = 5'd0;
      end
      S_CHECK: w_load = ~w_last;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_in3   <= '0;
      r_in4   <= '0;
      r_mask  <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_fv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mask  <= '0;
        r_err   <= '0;
        r_first <= '0;
        r_fv    <= 1'b0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_pass  <= 1'b0;
      end
      if (w_load) begin
        r_k <= w_k_load;
        for (int l = 0; l < WIDTH; l++) begin
          r_in1[l] <= w_stim[l][0];
          r_in2[l] <= w_stim[l][1];
          r_in3[l] <= w_stim[l][2];
          r_in4[l] <= w_stim[l][3];
        end
      end
      if (r_state == S_CHECK) begin
        if (w_any) begin
          r_err  <= w_err_nxt;
          r_mask <= r_mask | w_mis;
          if (!r_fv) begin
            r_first <= r_k;
            r_fv    <= 1'b1;
          end
        end
        if (w_stop) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= (w_err_nxt == 6'd0);
        end
      end
    end
  end

  assign o_in1        = r_in1;
  assign o_in2        = r_in2;
  assign o_in3        = r_in3;
  assign o_in4        = r_in4;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_count  = r_err;
  assign o_fail_mask  = r_mask;
  assign o_first_fail = r_first;
  assign o_fail_valid = r_fv;
endmodule

// File: tb/tb_oai22_bist.sv
// Directed + randomized bench for oai22_bist with an injectable-fault OAI22 array model.
module tb_oai22_bist;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] o_in1, o_in2, o_in3, o_in4, i_dut_out, o_fail_mask;
  logic         o_busy, o_done, o_pass, o_fail_valid;
  logic [5:0]   o_err_count;
  logic [4:0]   o_first_fail;

  int           n_chk = 0;
  int           n_fail = 0;
  int           mode = 0;
  logic [W-1:0] flip [32];

  oai22_bist #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_in1(o_in1), .o_in2(o_in2), .o_in3(o_in3), .o_in4(o_in4),
    .i_dut_out(i_dut_out), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_err_count(o_err_count), .o_fail_mask(o_fail_mask),
    .o_first_fail(o_first_fail), .o_fail_valid(o_fail_valid)
  );

  always #5 clk = ~clk;

  // Gate array under test: mode 0 clean, 1 lane3 stuck-at-1, 2 lane1 tied to lane0, 3 random per-vector flips
  function automatic logic [W-1:0] gate(input int m, input logic [W-1:0] a, b, c, d);
    logic [W-1:0] g;
    logic [4:0]   kk;
    g  = ~((a | b) & (c | d));
    kk = {a[0] ^ a[1], d[0], c[0], b[0], a[0]};
    case (m)
      1: g[3] = 1'b1;
      2: g[1] = g[0];
      3: g = g ^ flip[kk];
      default: ;
    endcase
    return g;
  endfunction

  always_comb i_dut_out = gate(mode, o_in1, o_in2, o_in3, o_in4);

  // Input j (0..3 for in1..in4) of every lane for vector k
  function automatic logic [W-1:0] vin(input int k, input int j);
    logic [W-1:0] r;
    logic [3:0]   v;
    for (int l = 0; l < W; l++) begin
      v = k[3:0];
      if (k >= 16 && (l % 2) == 1) v = ~v;
      r[l] = v[j];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] golden(input int k);
    logic [W-1:0] r;
    int s;
    for (int l = 0; l < W; l++) begin
      s = 0;
      if (k >= 16 && (l % 2) == 1) s = 15 - (k % 16); else s = k % 16;
      r[l] = !(((s % 2) != 0 || ((s / 2) % 2) != 0) && (((s / 4) % 2) != 0 || (s / 8) != 0));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic in_is(input int k);
    return o_in1 === vin(k, 0) && o_in2 === vin(k, 1) && o_in3 === vin(k, 2) && o_in4 === vin(k, 3);
  endfunction

  task automatic run(input int m, input int repulse, input string tag);
    int           e_err, e_first, e_edge, e_vec, n;
    logic [W-1:0] e_mask, mis;
    logic         stim_ok, busy_ok;
    mode = m;
    e_err = 0; e_mask = '0; e_first = -1;
    for (int k = 0; k < 32; k++) begin
      mis = gate(m, vin(k, 0), vin(k, 1), vin(k, 2), vin(k, 3)) ^ golden(k);
      if (mis != 0) begin
        e_err++;
        e_mask |= mis;
        if (e_first < 0) e_first = k;
      end
    end
    e_edge = 64; e_vec = 31;
`ifdef OAI22_BIST_STOP_ON_FAIL_EN
    if (e_first >= 0) begin
      e_edge = 2 * e_first + 2;
      e_vec  = (e_first == 31) ? 31 : e_first + 1;
      e_err  = 1;
      e_mask = gate(m, vin(e_first, 0), vin(e_first, 1), vin(e_first, 2), vin(e_first, 3)) ^ golden(e_first);
    end
`endif
    @(negedge clk); i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    chk({tag, " busy@0"}, o_busy, 1);
    chk({tag, " cleared@0"}, {o_done, o_err_count, o_fail_valid, o_fail_mask}, 0);
    n = 0; stim_ok = 1'b1; busy_ok = 1'b1;
    while (!o_done && n < 200) begin
      @(negedge clk); i_start = (n + 1 == repulse);
      @(posedge clk); n++; #1; i_start = 1'b0;
      if (!o_done) begin
        busy_ok &= o_busy;
        if (n % 2 == 0) stim_ok &= in_is(n / 2);
      end
    end
    chk({tag, " done_edge"}, n, e_edge);
    chk({tag, " stim_seq"}, stim_ok, 1);
    chk({tag, " busy_run"}, busy_ok, 1);
    chk({tag, " busy_end"}, o_busy, 0);
    chk({tag, " err_count"}, o_err_count, e_err);
    chk({tag, " fail_mask"}, o_fail_mask, e_mask);
    chk({tag, " fail_valid"}, o_fail_valid, e_first >= 0);
    if (e_first >= 0) chk({tag, " first_fail"}, o_first_fail, e_first);
    chk({tag, " pass"}, o_pass, e_first < 0);
    chk({tag, " final_vec"}, in_is(e_vec), 1);
    repeat (3) @(posedge clk);
    #1 chk({tag, " done_held"}, o_done, 1);
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {o_in1, o_in2, o_in3, o_in4, o_busy, o_done, o_pass, o_err_count,
              o_fail_mask, o_first_fail, o_fail_valid}, 0);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) flip[k] = '0;
    #12 all_zero("reset_state");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 all_zero("idle_no_start");

    run(0, -1, "clean");
    chk("clean pass", o_pass, 1);

    run(1, -1, "lane3_sa1");
`ifdef OAI22_BIST_STOP_ON_FAIL_EN
    chk("lane3 stop err", o_err_count, 1);
    chk("lane3 stop first", o_first_fail, 5);
    chk("lane3 stop vec6", in_is(6), 1);
`else
    chk("lane3 err", o_err_count, 18);
    chk("lane3 mask", o_fail_mask, 8'h08);
    chk("lane3 first", o_first_fail, 5);
`endif

    run(2, -1, "lane1_tie");
`ifndef OAI22_BIST_STOP_ON_FAIL_EN
    chk("tie err", o_err_count, 10);
    chk("tie mask", o_fail_mask, 8'h02);
`endif
    chk("tie first", o_first_fail, 16);

    run(0, 20, "repulse");

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 32; k++)
        flip[k] = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      run(3, -1, "random");
    end

    // Asynchronous reset in the middle of a faulty run
    mode = 1;
    @(negedge clk); i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 all_zero("async_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 all_zero("idle_after_reset");

    run(1, -1, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/oai22_bist.md
# oai22_bist

Built-in self-test engine for the generic OAI22 gate array. It drives exhaustive 4-input vectors onto a WIDTH-lane OAI22 instance and samples its output against an internal reference. It accumulates error statistics and reports pass/fail. It sits beside the gate library as its stimulus/checker end, used in gate-level bring-up and in library regression benches.

## Interface
- WIDTH, 8, number of 1-bit lanes in the gate array under test (1..64)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a test run; sampled only in IDLE or DONE
- in1  output  WIDTH  stimulus to gate in1
- in2  output  WIDTH  stimulus to gate in2
- in3  output  WIDTH  stimulus to gate in3
- in4  output  WIDTH  stimulus to gate in4
- dut_out  input  WIDTH  gate array output; combinational from in1..in4
- busy  output  1  run in progress
- done  output  1  run finished; held until next accepted start or reset
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  6  number of vectors with any lane mismatch (0..32)
- fail_mask  output  WIDTH  OR over the run of per-lane mismatch bits
- first_fail  output  5  index of first mismatching vector; valid when fail_valid=1
- fail_valid  output  1  at least one mismatch seen this run

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- Vector index k is 5 bits, 0..31. v=k[3:0]. Bit k[4] selects the pass.
- Pass 0 (k<16): all lanes get in1=v[0], in2=v[1], in3=v[2], in4=v[3].
- Pass 1 (k>=16): even lanes get v; odd lanes get ~v on all four inputs. This detects lane-to-lane shorts.
- Expected per lane: ~((a|b)&(c|d)), where a..d are the bits driven on that lane. Mismatch vector: dut_out ^ expected.
- IDLE/DONE + start=1:
  - load vector 0 onto in*
  - clear err_count, fail_mask, first_fail, fail_valid
  - done<=0, busy<=1
  - go to SETTLE
- SETTLE -> CHECK unconditionally. This is the one settle cycle for the combinational DUT.
- CHECK:
  - If the mismatch vector is nonzero:
    - err_count+=1
    - fail_mask|=mismatch
    - if fail_valid=0, first_fail<=k and fail_valid<=1
  - If k==31: go to DONE, busy<=0, done<=1, pass<=(final err_count==0).
  - Otherwise: load vector k+1 and go to SETTLE.
- start while busy=1 is ignored.
- start=1 in DONE begins a new run directly; all statistics are cleared.
- Reset (async, any state):
  - state IDLE
  - in1..in4=0, busy=0, done=0, pass=0
  - err_count=0, fail_mask=0, first_fail=0, fail_valid=0
- Reset mid-run discards all results. No partial done is ever produced.
- err_count cannot overflow: 6 bits, maximum 32.

## Timing
- Edge 0 is the edge that accepts start. Vector k appears on in* after edge 2k and is compared at edge 2k+2.
- Full run: the last compare is at edge 64. busy is high after edge 0 through edge 63. done=1 and busy=0 after edge 64.
- Outputs are all registered. No combinational path from dut_out or start to any output.
- dut_out must settle within one clock period of an in* change.

## Configuration
- OAI22_BIST_STOP_ON_FAIL_EN
  - Defined: in CHECK, any mismatch transitions directly to DONE after recording. The run ends with err_count=1, fail_valid=1 and pass=0.
  - Undefined: all 32 vectors always run.
- The macro has no effect when the DUT is fault-free.

## Test plan
- Fault-free behavioural OAI22 (WIDTH=8), start pulse:
  - done after edge 64
  - pass=1, err_count=0, fail_mask=0x00, fail_valid=0
- Lane 3 stuck-at-1:
  - err_count=18, fail_mask=0x08
  - first_fail=5, fail_valid=1, pass=0
- dut_out[1] tied to the lane-0 expected value:
  - pass 0 clean
  - err_count=10, fail_mask=0x02, first_fail=16
- OAI22_BIST_STOP_ON_FAIL_EN defined with the lane-3 stuck-at-1 fault:
  - done after edge 12
  - err_count=1, first_fail=5
  - in* frozen at vector 6
- start re-pulsed at edge 20 of a run:
  - ignored; done still after edge 64 with unchanged results
  - a second start in DONE restarts the run and clears statistics
- rst_n low at edge 30:
  - all outputs 0 immediately (asynchronously)
  - after release, state is IDLE and stays there until the next start
